oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 113 +++++++++++
 tb/tb_oam_dma.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite attribute DMA engine: a CPU write to the trigger register copies LENGTH
// bytes from page {src_page,00} to DEST_BASE, one byte every three cycles.
`timescale 1ns/1ps
module oam_dma #(
   parameter logic [15:0] REG_ADDR  = 16'hff46,
   parameter logic [15:0] DEST_BASE = 16'hfe00,
   parameter int          LENGTH    = 160
) (
   input  logic        clockgb,
   input  logic        resetn,
   input  logic [15:0] address,
   input  logic [7:0]  indata,
   output logic [7:0]  outdata,
   input  logic        load,
   input  logic        store,
   output logic [15:0] dma_address,
   output logic [7:0]  dma_outdata,
   input  logic [7:0]  dma_indata,
   output logic        dma_load,
   output logic        dma_store,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] src_page;
   logic [7:0] idx;
   logic [7:0] data_latch;
   logic       done_q;
   logic       read_sel;
   logic       trigger;
   logic       last_byte;

   assign trigger   = store && (address == REG_ADDR);
   assign last_byte = (idx == LAST_IDX);

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A trigger overrides whatever the engine was doing; the current cycle's
   // strobe still goes out because outputs decode the present state only.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = IDLE;
         READ:    state_next = CAPTURE;
         CAPTURE: state_next = WRITE;
         WRITE:   state_next = last_byte ? IDLE : READ;
         default: state_next = IDLE;
      endcase
      if (trigger) begin
         state_next = READ;
      end
   end

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         src_page   <= 8'h00;
         idx        <= 8'h00;
         data_latch <= 8'h00;
         done_q     <= 1'b0;
         read_sel   <= 1'b0;
      end else begin
         if (trigger) begin
            src_page <= indata;
            idx      <= 8'h00;
         end else if (state == WRITE && !last_byte) begin
            idx <= idx + 8'h01;
         end
         if (state == CAPTURE) begin
            data_latch <= dma_indata;
         end
         // An aborted transfer never reports completion.
         done_q   <= (state == WRITE) && last_byte && !trigger;
         read_sel <= load && (address == REG_ADDR);
      end
   end

   always_comb begin
      dma_load    = 1'b0;
      dma_store   = 1'b0;
      dma_address = 16'h0000;
      dma_outdata = 8'h00;
      case (state)
         READ: begin
            dma_load    = 1'b1;
            dma_address = {src_page, idx};
         end
         WRITE: begin
            dma_store   = 1'b1;
            dma_address = DEST_BASE + {8'h00, idx};
            dma_outdata = data_latch;
         end
         default: begin
         end
      endcase
   end

   assign busy    = (state != IDLE);
   assign done    = done_q;
   assign outdata = read_sel ? src_page : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory returns (address low byte ^ 8'h5A),
// so every destination write must carry (idx ^ 8'h5A).
`timescale 1ns/1ps
module tb_oam_dma;

   logic        clockgb = 1'b0;
   logic        resetn;
   logic [15:0] address;
   logic [7:0]  indata;
   logic [7:0]  outdata;
   logic        load;
   logic        store;
   logic [15:0] dma_address;
   logic [7:0]  dma_outdata;
   logic [7:0]  dma_indata;
   logic        dma_load;
   logic        dma_store;
   logic        busy;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;
   int busy_cycles  = 0;
   int done_pulses  = 0;
   int wr_count     = 0;
   int wr_bad       = 0;
   int rd_count     = 0;
   int excl_bad     = 0;
   int idle_bad     = 0;
   int b_busy, b_done, b_wr, b_rd, b_wrbad;

   oam_dma dut (
      .clockgb     (clockgb),
      .resetn      (resetn),
      .address     (address),
      .indata      (indata),
      .outdata     (outdata),
      .load        (load),
      .store       (store),
      .dma_address (dma_address),
      .dma_outdata (dma_outdata),
      .dma_indata  (dma_indata),
      .dma_load    (dma_load),
      .dma_store   (dma_store),
      .busy        (busy),
      .done        (done)
   );

   always #5 clockgb = ~clockgb;

   // Source memory with one-cycle read latency; garbage when not read.
   always @(posedge clockgb) begin
      dma_indata <= dma_load ? (dma_address[7:0] ^ 8'h5A) : 8'hEE;
   end

   always @(negedge clockgb) begin
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (dma_load) rd_count++;
      if (dma_store) begin
         wr_count++;
         if (dma_address[15:8] !== 8'hFE || dma_outdata !== (dma_address[7:0] ^ 8'h5A)) wr_bad++;
      end
      if (dma_load && dma_store) excl_bad++;
      if (!busy && (dma_load || dma_store || dma_address != 16'h0 || dma_outdata != 8'h0)) idle_bad++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clockgb);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("[TB] %s check did not hold", tag);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data, input logic wr, input logic rd);
      address = addr;
      indata  = data;
      store   = wr;
      load    = rd;
      tick(1);
      address = 16'h0;
      indata  = 8'h0;
      store   = 1'b0;
      load    = 1'b0;
   endtask

   task automatic snapshot();
      b_busy  = busy_cycles;
      b_done  = done_pulses;
      b_wr    = wr_count;
      b_rd    = rd_count;
      b_wrbad = wr_bad;
   endtask

   initial begin
      resetn  = 1'b0;
      address = 16'h0;
      indata  = 8'h0;
      load    = 1'b0;
      store   = 1'b0;
      tick(3);
      check_output("reset_busy", busy, 1'b0);
      check_output("reset_addr", dma_address, 16'h0000);
      check_output("reset_outdata", outdata, 8'h00);
      check_output("reset_done", done, 1'b0);
      resetn = 1'b1;
      tick(2);

      // Full transfer from page C1; trigger cycle T, READ at T+1.
      snapshot();
      apply_stimulus(16'hff46, 8'hC1, 1'b1, 1'b0);
      check_output("t1_first_load", dma_load, 1'b1);
      check_output("t1_first_raddr", dma_address, 16'hC100);
      check_output("t1_first_nostore", dma_store, 1'b0);
      apply_stimulus(16'hff46, 8'h00, 1'b0, 1'b1);
      check_output("t1_reg_read", outdata, 8'hC1);
      check_output("t1_capture_quiet", {dma_load, dma_store}, 2'b00);
      apply_stimulus(16'hff47, 8'h00, 1'b0, 1'b1);
      check_output("t1_other_read", outdata, 8'h00);
      check_output("t1_first_write", {dma_store, dma_address, dma_outdata}, {1'b1, 16'hFE00, 8'h5A});
      tick(477);
      check_output("t1_last_write", {dma_store, dma_address, dma_outdata}, {1'b1, 16'hFE9F, 8'hC5});
      check_output("t1_last_busy", busy, 1'b1);
      tick(1);
      check_output("t1_done_pulse", {busy, done}, 2'b01);
      tick(1);
      check_output("t1_done_single", done, 1'b0);
      check_output("t1_busy_cycles", busy_cycles - b_busy, 480);
      check_output("t1_writes", wr_count - b_wr, 160);
      check_output("t1_write_data", wr_bad - b_wrbad, 0);
      check_output("t1_done_count", done_pulses - b_done, 1);

      // Store elsewhere must not start the engine or touch src_page.
      apply_stimulus(16'hff47, 8'h55, 1'b1, 1'b0);
      check_output("other_store_idle", busy, 1'b0);
      apply_stimulus(16'hff46, 8'h00, 1'b0, 1'b1);
      check_output("other_store_page", outdata, 8'hC1);

      // Retrigger with D0 during the READ of idx 50 (cycle T+151): 151 busy
      // cycles of the aborted transfer plus 480 for the new one.
      snapshot();
      apply_stimulus(16'hff46, 8'hC1, 1'b1, 1'b0);
      tick(150);
      check_output("t2_read_idx50", {dma_load, dma_address}, {1'b1, 16'hC132});
      apply_stimulus(16'hff46, 8'hD0, 1'b1, 1'b0);
      check_output("t2_restart_read", {dma_load, dma_address}, {1'b1, 16'hD000});
      tick(479);
      check_output("t2_last_write", {dma_store, dma_address}, {1'b1, 16'hFE9F});
      tick(1);
      check_output("t2_done_pulse", {busy, done}, 2'b01);
      tick(1);
      check_output("t2_busy_cycles", busy_cycles - b_busy, 631);
      check_output("t2_done_count", done_pulses - b_done, 1);
      check_output("t2_writes", wr_count - b_wr, 210);
      check_output("t2_write_data", wr_bad - b_wrbad, 0);

      // Retrigger with 80 during the final WRITE: that write lands, done suppressed.
      snapshot();
      apply_stimulus(16'hff46, 8'hC1, 1'b1, 1'b0);
      tick(479);
      check_output("t3_final_write", {dma_store, dma_address, dma_outdata}, {1'b1, 16'hFE9F, 8'hC5});
      apply_stimulus(16'hff46, 8'h80, 1'b1, 1'b0);
      check_output("t3_no_done", done, 1'b0);
      check_output("t3_restart_read", {dma_load, dma_address}, {1'b1, 16'h8000});
      tick(479);
      tick(1);
      check_output("t3_done_pulse", {busy, done}, 2'b01);
      tick(1);
      check_output("t3_done_count", done_pulses - b_done, 1);
      check_output("t3_writes", wr_count - b_wr, 320);

      // Asynchronous reset during the READ of idx 20.
      apply_stimulus(16'hff46, 8'hC1, 1'b1, 1'b0);
      tick(60);
      check_output("t4_read_idx20", {dma_load, dma_address}, {1'b1, 16'hC114});
      resetn = 1'b0;
      #1;
      check_output("t4_async_outputs", {busy, done, dma_load, dma_store, dma_address, dma_outdata, outdata},
                   {4'b0000, 16'h0000, 8'h00, 8'h00});
      tick(2);
      resetn = 1'b1;
      snapshot();
      tick(20);
      check_output("t4_no_strobes", (wr_count - b_wr) + (rd_count - b_rd) + (busy_cycles - b_busy), 0);
      apply_stimulus(16'hff46, 8'h00, 1'b0, 1'b1);
      check_output("t4_page_cleared", outdata, 8'h00);

      // Page FF: 16-bit source addresses, no carry out of the page.
      snapshot();
      apply_stimulus(16'hff46, 8'hFF, 1'b1, 1'b0);
      check_output("t5_first_read", {dma_load, dma_address}, {1'b1, 16'hFF00});
      tick(477);
      check_output("t5_last_read", {dma_load, dma_address}, {1'b1, 16'hFF9F});
      tick(2);
      check_output("t5_last_write", {dma_store, dma_address, dma_outdata}, {1'b1, 16'hFE9F, 8'hC5});
      tick(2);
      check_output("t5_writes", wr_count - b_wr, 160);
      check_output("t5_write_data", wr_bad - b_wrbad, 0);

      check_output("strobe_exclusive", excl_bad, 0);
      check_output("idle_outputs_zero", idle_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
